// File: rtl/tick_sched_pkg.sv
// Shared defaults, arbiter state encoding and the round-robin pick helper
// for the tick scheduler.
package tick_sched_pkg;

  localparam int NCH_DEF  = 4;
  localparam int CNTW_DEF = 27;
  localparam int NCH_MAX  = 8;

  typedef enum logic {
    IDLE  = 1'b0,
    OFFER = 1'b1
  } arb_state_e;

  typedef struct packed {
    logic       found;
    logic [2:0] idx;
  } rr_pick_t;

  // First set bit of req[n-1:0], scanning ptr, ptr+1, ... wrapping at n.
  function automatic rr_pick_t rr_pick(input logic [NCH_MAX-1:0] req,
                                       input logic [2:0]         ptr,
                                       input int                 n);
    rr_pick_t   r;
    int         c;
    logic [2:0] c3;
    r = '0;
    for (int k = 0; k < NCH_MAX; k++) begin
      if (k < n) begin
        c  = (int'({29'd0, ptr}) + k) % n;
        c3 = c[2:0];
        if (!r.found && req[c3]) begin
          r.found = 1'b1;
          r.idx   = c3;
        end
      end
    end
    return r;
  endfunction

endpackage

// File: rtl/tick_sched_chan.sv
// One timer channel: period/enable/one-shot registers, a free-running counter
// and a registered one-cycle tick on expiry.
module tick_chan
  import tick_sched_pkg::*;
#(
  parameter int CNTW = CNTW_DEF
) (
  input  logic            high,
  input  logic            rst,
  input  logic            cfg_load,
  input  logic [CNTW-1:0] cfg_period,
  input  logic            cfg_en,
  input  logic            cfg_oneshot,
  output logic            expire,
  output logic            tick
);

  logic [CNTW-1:0] period_q;
  logic [CNTW-1:0] cnt_q;
  logic [CNTW-1:0] last;
  logic            en_q;
  logic            oneshot_q;
  logic            active;

  assign active = en_q && (period_q != '0);
  assign last   = period_q - CNTW'(1);
  // A config write in the expiry cycle restarts the channel instead of firing.
  assign expire = active && (cnt_q == last) && !cfg_load;

  always_ff @(posedge high) begin
    if (rst) begin
      period_q  <= '0;
      cnt_q     <= '0;
      en_q      <= 1'b0;
      oneshot_q <= 1'b0;
      tick      <= 1'b0;
    end else begin
      // NOTE: sequential state uses non-blocking <= so every flop samples pre-edge values.
      tick <= expire;
      if (cfg_load) begin
        period_q  <= cfg_period;
        en_q      <= cfg_en;
        oneshot_q <= cfg_oneshot;
        cnt_q     <= '0;
      end else if (active) begin
        if (cnt_q == last) begin
          cnt_q <= '0;
          if (oneshot_q) en_q <= 1'b0;
        end else begin
          cnt_q <= cnt_q + CNTW'(1);
        end
      end
    end
  end

endmodule

// File: rtl/tick_sched.sv
// Multi-channel tick scheduler: NCH programmable timers whose expiries latch
// into pending flags, served one at a time through a round-robin valid/ready port.
module tick_sched
  import tick_sched_pkg::*;
#(
  parameter  int NCH  = NCH_DEF,
  parameter  int CNTW = CNTW_DEF,
  localparam int IDXW = $clog2(NCH)
) (
  input  logic            high,
  input  logic            rst,
  input  logic            cfg_we,
  input  logic [IDXW-1:0] cfg_idx,
  input  logic [CNTW-1:0] cfg_period,
  input  logic            cfg_en,
  input  logic            cfg_oneshot,
  output logic [NCH-1:0]  tick,
  output logic [NCH-1:0]  pend,
  output logic [NCH-1:0]  ovf,
  input  logic            ovf_clr,
  output logic            svc_valid,
  output logic [IDXW-1:0] svc_id,
  input  logic            svc_ready
);

  arb_state_e      state_q, state_d;
  logic [IDXW-1:0] svc_id_q, svc_id_d;
  logic [IDXW-1:0] rr_ptr_q, rr_ptr_d;
  logic [NCH-1:0]  pend_q, pend_d;
  logic [NCH-1:0]  ovf_q, ovf_d;

  logic [NCH-1:0]     cfg_hit;
  logic [NCH-1:0]     acc;
  logic [NCH-1:0]     expire;
  logic               hs;
  logic [IDXW-1:0]    nxt_ptr;
  logic [IDXW-1:0]    pick_ptr;
  logic [NCH-1:0]     pick_req;
  logic [NCH_MAX-1:0] req_w;
  logic [2:0]         ptr_w;
  rr_pick_t           pick;
  logic               pick_unused;

  assign svc_valid = (state_q == OFFER);
  assign svc_id    = svc_id_q;
  assign pend      = pend_q;
  assign ovf       = ovf_q;
  assign hs        = svc_valid && svc_ready;

  always_comb begin
    for (int i = 0; i < NCH; i++) begin
      cfg_hit[i] = cfg_we && (cfg_idx == IDXW'(i));
      acc[i]     = hs && (svc_id_q == IDXW'(i));
    end
  end

  for (genvar g = 0; g < NCH; g++) begin : g_chan
    tick_chan #(.CNTW(CNTW)) u_chan (
      .high        (high),
      .rst         (rst),
      .cfg_load    (cfg_hit[g]),
      .cfg_period  (cfg_period),
      .cfg_en      (cfg_en),
      .cfg_oneshot (cfg_oneshot),
      .expire      (expire[g]),
      .tick        (tick[g])
    );
  end

  // Pending/overflow bookkeeping; a config write beats everything on its channel.
  always_comb begin
    // NOTE: every variable gets a default first so no latch is inferred.
    pend_d = pend_q;
    ovf_d  = ovf_clr ? '0 : ovf_q;
    for (int i = 0; i < NCH; i++) begin
      if (cfg_hit[i]) begin
        pend_d[i] = 1'b0;
        ovf_d[i]  = 1'b0;
      end else if (expire[i]) begin
        pend_d[i] = 1'b1;
        if (pend_q[i] && !acc[i]) ovf_d[i] = 1'b1;
      end else if (acc[i]) begin
        pend_d[i] = 1'b0;
      end
    end
  end

  // A single pick serves both the IDLE scan and the re-arbitration on a
  // handshake, so back-to-back offers need no extra cycle.
  always_comb begin
    nxt_ptr  = (svc_id_q == IDXW'(NCH - 1)) ? '0 : svc_id_q + IDXW'(1);
    pick_ptr = hs ? nxt_ptr : rr_ptr_q;
    pick_req = pend_q & ~cfg_hit & ~acc;
    req_w    = '0;
    req_w[NCH-1:0] = pick_req;
    ptr_w    = '0;
    ptr_w[IDXW-1:0] = pick_ptr;
    pick     = rr_pick(req_w, ptr_w, NCH);
  end

  assign pick_unused = ^pick.idx;

  always_comb begin
    state_d  = state_q;
    svc_id_d = svc_id_q;
    rr_ptr_d = rr_ptr_q;
    case (state_q)
      IDLE: begin
        if (pick.found) begin
          state_d  = OFFER;
          svc_id_d = pick.idx[IDXW-1:0];
        end
      end
      OFFER: begin
        if (hs) begin
          rr_ptr_d = nxt_ptr;
          if (pick.found) begin
            svc_id_d = pick.idx[IDXW-1:0];
          end else begin
            state_d = IDLE;
          end
        end else if (cfg_hit[svc_id_q]) begin
          state_d = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge high) begin
    if (rst) begin
      state_q  <= IDLE;
      svc_id_q <= '0;
      rr_ptr_q <= '0;
      pend_q   <= '0;
      ovf_q    <= '0;
    end else begin
      state_q  <= state_d;
      svc_id_q <= svc_id_d;
      rr_ptr_q <= rr_ptr_d;
      pend_q   <= pend_d;
      ovf_q    <= ovf_d;
    end
  end

endmodule
